// File: rtl/tt_sel_drv.sv
// Mux-select driver: steps an external select counter (reset + increment pulses)
// to a requested design address, with the mux enable held off while it moves.
module tt_sel_drv #(
    parameter int unsigned PULSE_W = 2,
    parameter int unsigned RST_W   = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       req_valid,
    output logic       req_ready,
    input  logic [9:0] req_addr,
    input  logic       req_ena,
    input  logic       req_force_rst,
    output logic       ctrl_sel_rst_n,
    output logic       ctrl_sel_inc,
    output logic       ctrl_ena,
    output logic [9:0] cur_addr,
    output logic       cur_valid,
    output logic       busy
);

    typedef enum logic [2:0] {IDLE, DIS, RST, INC_H, INC_L, ENA} state_t;

    localparam logic [7:0] PW_LD  = 8'(PULSE_W - 1);
    localparam logic [7:0] RST_LD = 8'(RST_W - 1);

    state_t     state_q, state_d;
    logic [7:0] timer_q, timer_d;
    logic [9:0] cnt_q, cnt_d;
    logic [9:0] tgt_q, tgt_d;
    logic       ena_lat_q, ena_lat_d;
    logic       need_rst_q, need_rst_d;

    logic       sel_rst_n_d, sel_inc_d, ctrl_ena_d, cur_valid_d;
    logic       ready_d;
    logic [9:0] cur_addr_d;

    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    always_comb begin
        state_d    = state_q;
        timer_d    = timer_q;
        cnt_d      = cnt_q;
        tgt_d      = tgt_q;
        ena_lat_d  = ena_lat_q;
        need_rst_d = need_rst_q;

        unique case (state_q)
            IDLE, ENA: begin
                state_d = IDLE;
                // req_ready is already high in ENA, so a new request can be taken there.
                if (req_valid && req_ready) begin
                    state_d    = DIS;
                    timer_d    = PW_LD;
                    tgt_d      = req_addr;
                    ena_lat_d  = req_ena;
                    need_rst_d = !cur_valid || req_force_rst;
                    cnt_d      = need_rst_d ? req_addr : req_addr - cur_addr;
                end
            end
            DIS: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else if (need_rst_q) begin
                    state_d = RST;
                    timer_d = RST_LD;
                end else if (cnt_q == 10'd0) begin
                    state_d = ENA;
                end else begin
                    state_d = INC_H;
                    timer_d = PW_LD;
                end
            end
            RST: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else if (cnt_q == 10'd0) begin
                    state_d = ENA;
                end else begin
                    state_d = INC_H;
                    timer_d = PW_LD;
                end
            end
            INC_H: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    state_d = INC_L;
                    timer_d = PW_LD;
                end
            end
            INC_L: begin
                if (timer_q != 8'd0) begin
                    timer_d = timer_q - 8'd1;
                end else begin
                    cnt_d   = cnt_q - 10'd1;
                    state_d = (cnt_d == 10'd0) ? ENA : INC_H;
                    timer_d = PW_LD;
                end
            end
            default: state_d = IDLE;
        endcase

        // Outputs are registered from the next state so they line up with the state they describe.
        sel_inc_d   = (state_d == INC_H);
        ready_d     = (state_d == IDLE) || (state_d == ENA);
        sel_rst_n_d = ctrl_sel_rst_n;
        ctrl_ena_d  = ctrl_ena;
        cur_addr_d  = cur_addr;
        cur_valid_d = cur_valid;

        unique case (state_d)
            DIS:          ctrl_ena_d = 1'b0;
            RST: begin
                sel_rst_n_d = 1'b0;
                ctrl_ena_d  = 1'b0;
            end
            INC_H, INC_L: begin
                sel_rst_n_d = 1'b1;
                ctrl_ena_d  = 1'b0;
            end
            ENA: begin
                sel_rst_n_d = 1'b1;
                ctrl_ena_d  = ena_lat_d;
                cur_addr_d  = tgt_d;
                cur_valid_d = 1'b1;
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop samples pre-edge values.
    // NOTE: all registers, including the request latches, are reset; they are few and reset abandons the request.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            timer_q        <= 8'd0;
            cnt_q          <= 10'd0;
            tgt_q          <= 10'd0;
            ena_lat_q      <= 1'b0;
            need_rst_q     <= 1'b0;
            ctrl_sel_rst_n <= 1'b0;
            ctrl_sel_inc   <= 1'b0;
            ctrl_ena       <= 1'b0;
            cur_addr       <= 10'd0;
            cur_valid      <= 1'b0;
            req_ready      <= 1'b0;
            busy           <= 1'b0;
        end else begin
            state_q        <= state_d;
            timer_q        <= timer_d;
            cnt_q          <= cnt_d;
            tgt_q          <= tgt_d;
            ena_lat_q      <= ena_lat_d;
            need_rst_q     <= need_rst_d;
            ctrl_sel_rst_n <= sel_rst_n_d;
            ctrl_sel_inc   <= sel_inc_d;
            ctrl_ena       <= ctrl_ena_d;
            cur_addr       <= cur_addr_d;
            cur_valid      <= cur_valid_d;
            req_ready      <= ready_d;
            busy           <= !ready_d;
        end
    end

endmodule

// File: tb/tb_tt_sel_drv.sv
// Bench for tt_sel_drv: a phase-list model expands each request into per-cycle
// expectations, checked every cycle, plus literal pins on the worked examples.
module tb_tt_sel_drv;

    localparam int PW = 2;
    localparam int RW = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       req_valid = 1'b0;
    logic       req_ready;
    logic [9:0] req_addr = '0;
    logic       req_ena = 1'b0;
    logic       req_force_rst = 1'b0;
    logic       ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, cur_valid, busy;
    logic [9:0] cur_addr;

    tt_sel_drv #(.PULSE_W(PW), .RST_W(RW)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_addr      (req_addr),
        .req_ena       (req_ena),
        .req_force_rst (req_force_rst),
        .ctrl_sel_rst_n(ctrl_sel_rst_n),
        .ctrl_sel_inc  (ctrl_sel_inc),
        .ctrl_ena      (ctrl_ena),
        .cur_addr      (cur_addr),
        .cur_valid     (cur_valid),
        .busy          (busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst_n;
        logic       inc;
        logic       ena;
        logic       ready;
        logic       busy;
        logic       valid;
        logic [9:0] addr;
    } obs_t;

    obs_t exp_q[$];
    int   n_vec = 0;
    int   n_miss = 0;

    // Model of the outside world: what the mux counter holds and whether its reset was released.
    logic [9:0] m_addr = '0;
    bit         m_valid = 0;
    bit         m_rel = 0;

    // Per-request measurements taken from the observed outputs.
    int          idx, pulses, rst_low, first_ready, ena_low;
    logic [63:0] inc_mask;
    logic        prev_inc;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_vec++;
        if (act !== expv) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            obs_t e, a;
            e = exp_q.pop_front();
            a = '{ctrl_sel_rst_n, ctrl_sel_inc, ctrl_ena, req_ready, busy, cur_valid, cur_addr};
            idx++;
            n_vec++;
            if (a !== e) begin
                n_miss++;
                $display("FAIL cycle%0d {rst_n,inc,ena,ready,busy,valid,addr}: got %b expected %b", idx, a, e);
            end
            if (a.inc && !prev_inc) pulses++;
            prev_inc = a.inc;
            if (!a.rst_n) rst_low++;
            if (a.ready && first_ready == 0) first_ready = idx;
            if (!a.ena && !a.ready) ena_low++;
            if (idx < 64 && a.inc) inc_mask[idx] = 1'b1;
        end
    end

    task automatic start_req(input logic [9:0] addr, input logic ena, input logic force_rst);
        obs_t       b;
        bit         need;
        logic [9:0] cnt;
        @(negedge clk);
        #1;
        req_valid = 1'b1; req_addr = addr; req_ena = ena; req_force_rst = force_rst;
        idx = 0; pulses = 0; rst_low = 0; first_ready = 0; ena_low = 0;
        inc_mask = '0; prev_inc = 1'b0;

        need = !m_valid || force_rst;
        cnt  = need ? addr : addr - m_addr;
        b = '{m_rel, 1'b0, 1'b0, 1'b0, 1'b1, m_valid, m_addr};
        for (int i = 0; i < PW; i++) exp_q.push_back(b);
        if (need) begin
            b.rst_n = 1'b0;
            for (int i = 0; i < RW; i++) exp_q.push_back(b);
            m_rel   = 1;
            b.rst_n = 1'b1;
        end
        for (int p = 0; p < int'(cnt); p++) begin
            b.inc = 1'b1;
            for (int i = 0; i < PW; i++) exp_q.push_back(b);
            b.inc = 1'b0;
            for (int i = 0; i < PW; i++) exp_q.push_back(b);
        end
        b = '{m_rel, 1'b0, ena, 1'b1, 1'b0, 1'b1, addr};
        exp_q.push_back(b);
        exp_q.push_back(b);
        m_addr  = addr;
        m_valid = 1;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
    endtask

    task automatic wait_done();
        int b = 0;
        while (exp_q.size() > 0 && b < 20000) begin
            @(negedge clk);
            #1;
            b++;
        end
        check("sequence_timeout", exp_q.size(), 0);
        exp_q.delete();
    endtask

    initial begin
        #2;
        check("rst_sel_rst_n", ctrl_sel_rst_n, 0);
        check("rst_inc", ctrl_sel_inc, 0);
        check("rst_ena", ctrl_ena, 0);
        check("rst_ready", req_ready, 0);
        check("rst_busy", busy, 0);
        check("rst_addr_valid", {cur_valid, cur_addr}, 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("post_rst_ready", req_ready, 1);
        check("post_rst_sel_rst_n", ctrl_sel_rst_n, 0);

        // First request after reset: reset path, 3 pulses.
        start_req(10'd3, 1'b1, 1'b0);
        wait_done();
        check("s1_pulses", pulses, 3);
        check("s1_rst_low", rst_low, 6);
        check("s1_ready_cycle", first_ready, 19);
        check("s1_inc_mask", inc_mask[31:0], 32'h0001_9980);
        check("s1_ena_low", ena_low, 18);
        check("s1_addr", cur_addr, 3);

        // 3 -> 5 incremental, with a stray request held during busy that must be ignored.
        start_req(10'd5, 1'b1, 1'b0);
        repeat (2) @(negedge clk);
        #1;
        req_valid = 1'b1; req_addr = 10'd700; req_force_rst = 1'b1;
        repeat (5) @(negedge clk);
        #1;
        req_valid = 1'b0; req_force_rst = 1'b0;
        wait_done();
        check("s2_pulses", pulses, 2);
        check("s2_rst_low", rst_low, 0);
        check("s2_ready_cycle", first_ready, 11);
        check("s2_inc_mask", inc_mask[31:0], 32'h0000_0198);
        check("s2_ena_low", ena_low, 10);
        check("s2_addr", cur_addr, 5);

        // Same address, enable off: zero pulses.
        start_req(10'd5, 1'b0, 1'b0);
        wait_done();
        check("s3_pulses", pulses, 0);
        check("s3_ready_cycle", first_ready, 3);
        check("s3_ena", ctrl_ena, 0);
        check("s3_addr", cur_addr, 5);

        // Same address, forced reset: 4-cycle reset then 5 pulses.
        start_req(10'd5, 1'b1, 1'b1);
        wait_done();
        check("s4_pulses", pulses, 5);
        check("s4_rst_low", rst_low, 4);
        check("s4_ready_cycle", first_ready, 27);

        // Long incremental walk up to 1020, then a wrapping move to 2.
        start_req(10'd1020, 1'b1, 1'b0);
        wait_done();
        check("s5_pulses", pulses, 1015);
        check("s5_addr", cur_addr, 1020);
        start_req(10'd2, 1'b1, 1'b0);
        wait_done();
        check("s6_pulses", pulses, 6);
        check("s6_rst_low", rst_low, 0);
        check("s6_ready_cycle", first_ready, 27);
        check("s6_addr", cur_addr, 2);

        // Reset pulsed in the second INC_H of a 2 -> 9 move.
        start_req(10'd9, 1'b1, 1'b0);
        repeat (7) @(negedge clk);
        #1;
        check("s7_in_second_inc_h", {ctrl_sel_inc, 8'(pulses)}, {1'b1, 8'd2});
        exp_q.delete();
        rst_n = 1'b0;
        #1;
        check("s7_async_inc", ctrl_sel_inc, 0);
        check("s7_async_ena", ctrl_ena, 0);
        check("s7_async_sel_rst_n", ctrl_sel_rst_n, 0);
        check("s7_async_valid", cur_valid, 0);
        check("s7_async_ready_busy", {req_ready, busy}, 0);
        m_addr = '0; m_valid = 0; m_rel = 0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        #1;
        check("s7_ready_after_rst", req_ready, 1);

        // Next request must take the reset path.
        start_req(10'd2, 1'b1, 1'b0);
        wait_done();
        check("s8_pulses", pulses, 2);
        check("s8_rst_low", rst_low, 6);
        check("s8_ready_cycle", first_ready, 15);
        check("s8_addr", cur_addr, 2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
